ifft4_serial_loader: RTL and testbench
======================================

IFFT4_SERIAL_LOADER -- requirements
Module: ifft4_serial_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed two's-complement width of each real/imag component.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port s_valid  input  1  upstream sample valid.
REQ-005 SHALL have port s_ready  output  1  loader can accept a sample this cycle.
REQ-006 SHALL have ports s_real, s_imag  input  DATA_WIDTH each  signed sample components.
REQ-007 SHALL have port s_last  input  1  upstream marks final sample of a 4-sample frame.
REQ-008 SHALL have ports in0..in3_real, in0..in3_imag  output  DATA_WIDTH each  parallel frame toward the ifft4 stage.
REQ-009 SHALL have port frame_valid  output  1  parallel frame on in0..in3 is complete.
REQ-010 SHALL have port frame_ready  input  1  downstream takes the frame (drives ifft4 en = frame_valid & frame_ready).
REQ-011 SHALL have port sync_err  output  1  one-cycle pulse on frame-alignment error.

Function
REQ-012 SHALL accept a sample only on a cycle with s_valid & s_ready ("beat").
REQ-013 SHALL hold two frame buffers (ping/pong), each 4 complex slots plus a full flag; write pointer, read pointer, 2-bit write index.
REQ-014 SHALL write beat k (index 0..3) into slot k of the write buffer; on index 3 set the buffer full, toggle write pointer, return index to 0.
REQ-015 SHALL drive s_ready = rst_n & !(write buffer full).
REQ-016 SHALL drive frame_valid = read buffer full, registered: first asserted the cycle after the 4th beat is accepted; in0..3 = read buffer slots 0..3.
REQ-017 SHALL on frame_valid & frame_ready clear the read buffer full flag and toggle read pointer; frame data and frame_valid held stable until then.
REQ-018 SHALL support a 4th-beat commit and a frame handoff in the same cycle without loss; sustained 1 beat/cycle when frame_ready is high at least once per 4 cycles.
REQ-019 SHALL treat s_last=1 on a beat with index 0..2 as alignment error: discard the partial frame, index to 0, pulse sync_err next cycle; the offending sample is not stored.
REQ-020 SHALL commit a frame at index 3 regardless of s_last (s_last=0 there is not an error).
REQ-021 SHALL pass sample values unchanged (no scaling, no width change).

Reset
REQ-022 SHALL on a clock edge with rst_n=0 clear both full flags, both pointers, write index, sync_err, and all in0..3 outputs to 0; frame_valid=0, s_ready=0 while rst_n=0.
REQ-023 SHALL discard any partial or full frame on mid-operation reset; s_ready=1 first cycle after rst_n rises.

Configuration
REQ-024 SHALL, with IFFT4_LOADER_BITREV_EN defined, write beat k into slot bitrev2(k) (0->0,1->2,2->1,3->3); without it, natural order slot k.

Structure
REQ-025 SHALL place DATA_WIDTH default, frame length 4, and the bit-reverse slot map in shared package ifft4_pkg.
REQ-026 SHALL implement each buffer as one sub-module ifft4_frame_buf (4 slots, write-enable/slot select, full flag set/clear), instantiated twice.

Verification
REQ-027 SHALL cover: beats 1+j0, -2+j3, -1+j0, -2-j3 (s_last on 4th), frame_ready=1 -> frame_valid one cycle after 4th beat, in0..3 = same values in order.
REQ-028 SHALL cover: frame_ready=0, 8 continuous beats -> both buffers full, s_ready=0 after 8th; frame_ready=1 one cycle -> s_ready=1 next cycle, first frame delivered first.
REQ-029 SHALL cover: s_last=1 on beat 2 (index 1) -> sync_err pulse, no frame_valid; next 4 beats 5,6,7,8 -> frame 5,6,7,8.
REQ-030 SHALL cover: continuous beats with frame_ready=1 -> s_ready never drops, 4th-beat commit and handoff same cycle, 3 frames intact.
REQ-031 SHALL cover: rst_n=0 after 2 beats -> outputs 0, frame_valid=0; post-reset beats 9,10,11,12 -> frame 9,10,11,12.
REQ-032 SHALL cover: with IFFT4_LOADER_BITREV_EN, beats 1,2,3,4 -> in0..3_real = 1,3,2,4.

Source files
------------

// File: rtl/ifft4_pkg.sv
// ----------------------------------------------------------------------------
// ifft4_pkg
// Shared constants and helpers for the 4-point IFFT front end.
//   DATA_WIDTH_DEF : default width of each signed real/imag component
//   FRAME_LEN      : number of complex samples per frame (4)
//   slot_idx_t     : 2-bit slot / beat index type
//   bitrev2()      : bit-reversed slot map (0->0, 1->2, 2->1, 3->3)
// ----------------------------------------------------------------------------
package ifft4_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int FRAME_LEN      = 4;
    localparam int IDX_W          = 2;

    typedef logic [IDX_W-1:0] slot_idx_t;

    // Swapping the two index bits gives the radix-2 input ordering.
    function automatic slot_idx_t bitrev2(input slot_idx_t k);
        return {k[0], k[1]};
    endfunction

endpackage

// File: rtl/ifft4_frame_buf.sv
// ----------------------------------------------------------------------------
// ifft4_frame_buf
// One frame buffer: FRAME_LEN complex slots plus a full flag.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   i_wr_en, i_wr_slot   : write strobe and target slot
//   i_wr_real, i_wr_imag : sample components to store
//   i_set_full           : mark the frame complete
//   i_clr_full           : release the frame after downstream takes it
//   o_full               : frame complete flag
//   o_real, o_imag       : all slots, slot k at element k
// ----------------------------------------------------------------------------
module ifft4_frame_buf
    import ifft4_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_wr_en,
    input  slot_idx_t                            i_wr_slot,
    input  logic signed [DATA_WIDTH-1:0]         i_wr_real,
    input  logic signed [DATA_WIDTH-1:0]         i_wr_imag,
    input  logic                                 i_set_full,
    input  logic                                 i_clr_full,
    output logic                                 o_full,
    output logic [FRAME_LEN-1:0][DATA_WIDTH-1:0] o_real,
    output logic [FRAME_LEN-1:0][DATA_WIDTH-1:0] o_imag
);

    logic [FRAME_LEN-1:0][DATA_WIDTH-1:0] r_real;
    logic [FRAME_LEN-1:0][DATA_WIDTH-1:0] r_imag;
    logic                                 r_full;

    genvar gi;
    generate
        for (gi = 0; gi < FRAME_LEN; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_real[gi] <= '0;
                    r_imag[gi] <= '0;
                end else if (i_wr_en && (i_wr_slot == slot_idx_t'(gi))) begin
                    r_real[gi] <= i_wr_real;
                    r_imag[gi] <= i_wr_imag;
                end
            end
        end
    endgenerate

    // Set and clear never target the same buffer in one cycle: a buffer
    // being written is not full, and only a full buffer is handed off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (i_set_full) begin
            r_full <= 1'b1;
        end else if (i_clr_full) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_real = r_real;
    assign o_imag = r_imag;

endmodule

// File: rtl/ifft4_serial_loader.sv
// ----------------------------------------------------------------------------
// ifft4_serial_loader
// Collects a serial stream of complex samples into 4-sample frames using a
// ping/pong pair of frame buffers and presents each frame in parallel to
// the ifft4 stage.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   s_valid/s_ready       : upstream sample handshake
//   s_real, s_imag        : signed sample components
//   s_last                : upstream end-of-frame marker
//   in0..in3_real/imag    : parallel frame (read buffer slots 0..3)
//   frame_valid           : read buffer holds a complete frame
//   frame_ready           : downstream takes the frame this cycle
//   sync_err              : one-cycle pulse after a premature s_last
// Build option:
//   IFFT4_LOADER_BITREV_EN : when defined, beat k is stored in slot
//                            bitrev2(k); otherwise in slot k.
// ----------------------------------------------------------------------------
module ifft4_serial_loader
    import ifft4_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_real,
    input  logic signed [DATA_WIDTH-1:0] s_imag,
    input  logic                         s_last,
    output logic signed [DATA_WIDTH-1:0] in0_real,
    output logic signed [DATA_WIDTH-1:0] in0_imag,
    output logic signed [DATA_WIDTH-1:0] in1_real,
    output logic signed [DATA_WIDTH-1:0] in1_imag,
    output logic signed [DATA_WIDTH-1:0] in2_real,
    output logic signed [DATA_WIDTH-1:0] in2_imag,
    output logic signed [DATA_WIDTH-1:0] in3_real,
    output logic signed [DATA_WIDTH-1:0] in3_imag,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic                         sync_err
);

    localparam slot_idx_t LAST_IDX = slot_idx_t'(FRAME_LEN - 1);

    logic      r_wr_ptr;
    logic      r_rd_ptr;
    slot_idx_t r_wr_idx;
    logic      r_sync_err;

    logic                                       w_beat;
    logic                                       w_misaligned;
    logic                                       w_commit;
    logic                                       w_wr_en;
    logic                                       w_handoff;
    slot_idx_t                                  w_slot;
    logic [1:0]                                 w_buf_full;
    logic [1:0][FRAME_LEN-1:0][DATA_WIDTH-1:0]  w_buf_real;
    logic [1:0][FRAME_LEN-1:0][DATA_WIDTH-1:0]  w_buf_imag;
    logic [FRAME_LEN-1:0][DATA_WIDTH-1:0]       w_rd_real;
    logic [FRAME_LEN-1:0][DATA_WIDTH-1:0]       w_rd_imag;

    // s_ready depends only on registered state and rst_n, so a stalled
    // upstream never sees a combinational path from its own s_valid.
    assign s_ready      = rst_n & ~w_buf_full[r_wr_ptr];
    assign w_beat       = s_valid & s_ready;
    // s_last before the final slot means upstream lost alignment; the
    // sample is dropped and the partial frame abandoned.
    assign w_misaligned = w_beat & s_last & (r_wr_idx != LAST_IDX);
    // The final slot always closes a frame, whatever s_last says.
    assign w_commit     = w_beat & (r_wr_idx == LAST_IDX);
    assign w_wr_en      = w_beat & ~w_misaligned;

    assign frame_valid  = rst_n & w_buf_full[r_rd_ptr];
    assign w_handoff    = frame_valid & frame_ready;

`ifdef IFFT4_LOADER_BITREV_EN
    assign w_slot = bitrev2(r_wr_idx);
`else
    assign w_slot = r_wr_idx;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_idx   <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_misaligned;
            if (w_commit) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_handoff) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_misaligned) begin
                r_wr_idx <= '0;
            end else if (w_beat) begin
                r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + 2'd1;
            end
        end
    end

    // Ping/pong buffers: the write pointer selects which one takes beats,
    // the read pointer selects which one is presented downstream.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            ifft4_frame_buf #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_buf (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_wr_en    (w_wr_en & (r_wr_ptr == 1'(gi))),
                .i_wr_slot  (w_slot),
                .i_wr_real  (s_real),
                .i_wr_imag  (s_imag),
                .i_set_full (w_commit & (r_wr_ptr == 1'(gi))),
                .i_clr_full (w_handoff & (r_rd_ptr == 1'(gi))),
                .o_full     (w_buf_full[gi]),
                .o_real     (w_buf_real[gi]),
                .o_imag     (w_buf_imag[gi])
            );
        end
    endgenerate

    assign w_rd_real = w_buf_real[r_rd_ptr];
    assign w_rd_imag = w_buf_imag[r_rd_ptr];

    assign in0_real = w_rd_real[0];
    assign in1_real = w_rd_real[1];
    assign in2_real = w_rd_real[2];
    assign in3_real = w_rd_real[3];
    assign in0_imag = w_rd_imag[0];
    assign in1_imag = w_rd_imag[1];
    assign in2_imag = w_rd_imag[2];
    assign in3_imag = w_rd_imag[3];

    assign sync_err = r_sync_err;

endmodule

// File: tb/tb_ifft4_serial_loader.sv
// ----------------------------------------------------------------------------
// tb_ifft4_serial_loader
// Directed, table-driven bench for ifft4_serial_loader (DATA_WIDTH = 8).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// ----------------------------------------------------------------------------
module tb_ifft4_serial_loader;

    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_real;
    logic signed [DW-1:0] s_imag;
    logic                 s_last;
    logic signed [DW-1:0] in0_real, in0_imag, in1_real, in1_imag;
    logic signed [DW-1:0] in2_real, in2_imag, in3_real, in3_imag;
    logic                 frame_valid;
    logic                 frame_ready;
    logic                 sync_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ifft4_serial_loader #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_real      (s_real),
        .s_imag      (s_imag),
        .s_last      (s_last),
        .in0_real    (in0_real),
        .in0_imag    (in0_imag),
        .in1_real    (in1_real),
        .in1_imag    (in1_imag),
        .in2_real    (in2_real),
        .in2_imag    (in2_imag),
        .in3_real    (in3_real),
        .in3_imag    (in3_imag),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sync_err    (sync_err)
    );

    // One table row: inputs for one clock edge, expected outputs after it.
    typedef struct packed {
        logic                 v;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic                 last;
        logic                 fr;
        logic                 e_rdy;
        logic                 e_fv;
        logic                 e_err;
        logic [3:0]           fid;
    } vec_t;

    vec_t vecs [32];
    int   n_vec;

    // Expected frames, listed in beat order.
    int fre [8][4];
    int fim [8][4];

    function automatic vec_t mk(input logic v, input int re, input int im,
                                input logic last, input logic fr,
                                input logic e_rdy, input logic e_fv,
                                input logic e_err, input int fid);
        vec_t r;
        r.v     = v;
        r.re    = re[DW-1:0];
        r.im    = im[DW-1:0];
        r.last  = last;
        r.fr    = fr;
        r.e_rdy = e_rdy;
        r.e_fv  = e_fv;
        r.e_err = e_err;
        r.fid   = fid[3:0];
        return r;
    endfunction

    // Output slot s carries beat tb_map(s).
    function automatic int tb_map(input int s);
`ifdef IFFT4_LOADER_BITREV_EN
        return ((s & 1) << 1) | ((s >> 1) & 1);
`else
        return s;
`endif
    endfunction

    function automatic int get_re(input int k);
        case (k)
            0:       return int'(in0_real);
            1:       return int'(in1_real);
            2:       return int'(in2_real);
            default: return int'(in3_real);
        endcase
    endfunction

    function automatic int get_im(input int k);
        case (k)
            0:       return int'(in0_imag);
            1:       return int'(in1_imag);
            2:       return int'(in2_imag);
            default: return int'(in3_imag);
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int fid);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("%s in%0d_real", tag, s), get_re(s), fre[fid][tb_map(s)]);
            check($sformatf("%s in%0d_imag", tag, s), get_im(s), fim[fid][tb_map(s)]);
        end
    endtask

    task automatic apply(input logic v, input int re, input int im,
                         input logic last, input logic fr);
        @(negedge clk);
        s_valid     = v;
        s_real      = re[DW-1:0];
        s_imag      = im[DW-1:0];
        s_last      = last;
        frame_ready = fr;
        @(posedge clk);
        #1;
    endtask

    int nf;

    initial begin
        // Frame A (test vector of the basic load)
        fre[0] = '{1, -2, -1, -2};   fim[0] = '{0, 3, 0, -3};
        fre[1] = '{5, 6, 7, 8};      fim[1] = '{-5, -6, -7, -8};
        fre[2] = '{10, 11, 12, 13};  fim[2] = '{0, 0, 0, 0};
        fre[3] = '{14, 15, 16, 17};  fim[3] = '{0, 0, 0, 0};
        fre[4] = '{20, 21, 22, 23};  fim[4] = '{-20, -21, -22, -23};
        fre[5] = '{24, 25, 26, 27};  fim[5] = '{-24, -25, -26, -27};
        fre[6] = '{28, 29, 30, 31};  fim[6] = '{-28, -29, -30, -31};
        fre[7] = '{9, 10, 11, 12};   fim[7] = '{-9, -10, -11, -12};

        n_vec = 0;
        // Basic frame, ready downstream: frame_valid one cycle after beat 4.
        vecs[n_vec++] = mk(1,  1,  0, 0, 1, 1, 0, 0, 0);
        vecs[n_vec++] = mk(1, -2,  3, 0, 1, 1, 0, 0, 0);
        vecs[n_vec++] = mk(1, -1,  0, 0, 1, 1, 0, 0, 0);
        vecs[n_vec++] = mk(1, -2, -3, 1, 1, 1, 1, 0, 0);
        vecs[n_vec++] = mk(0,  0,  0, 0, 1, 1, 0, 0, 0);
        // Premature s_last on index 1: pulse, discard, then a clean frame.
        vecs[n_vec++] = mk(1, 3,  0, 0, 0, 1, 0, 0, 0);
        vecs[n_vec++] = mk(1, 4,  0, 1, 0, 1, 0, 1, 0);
        vecs[n_vec++] = mk(1, 5, -5, 0, 0, 1, 0, 0, 0);
        vecs[n_vec++] = mk(1, 6, -6, 0, 0, 1, 0, 0, 0);
        vecs[n_vec++] = mk(1, 7, -7, 0, 0, 1, 0, 0, 0);
        vecs[n_vec++] = mk(1, 8, -8, 1, 0, 1, 1, 0, 1);
        vecs[n_vec++] = mk(0, 0,  0, 0, 1, 1, 0, 0, 0);
        // Downstream stalled for 8 beats: both buffers fill, s_ready drops.
        for (int k = 0; k < 8; k++) begin
            vecs[n_vec++] = mk(1, 10 + k, 0, (k % 4) == 3, 0,
                               (k != 7), (k >= 3), 0, 2);
        end
        // One handoff: the rejected 99 is not taken, second frame appears.
        vecs[n_vec++] = mk(1, 99, 0, 0, 1, 1, 1, 0, 3);
        vecs[n_vec++] = mk(0,  0, 0, 0, 1, 1, 0, 0, 0);

        // Reset
        rst_n = 1'b0; s_valid = 1'b0; s_real = '0; s_imag = '0;
        s_last = 1'b0; frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset s_ready", int'(s_ready), 0);
        check("reset frame_valid", int'(frame_valid), 0);
        check("reset sync_err", int'(sync_err), 0);
        check("reset in0_real", int'(in0_real), 0);
        check("reset in3_imag", int'(in3_imag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset s_ready", int'(s_ready), 1);

        // Table
        for (int i = 0; i < n_vec; i++) begin
            apply(vecs[i].v, int'(vecs[i].re), int'(vecs[i].im),
                  vecs[i].last, vecs[i].fr);
            check($sformatf("vec%0d s_ready", i), int'(s_ready), int'(vecs[i].e_rdy));
            check($sformatf("vec%0d frame_valid", i), int'(frame_valid), int'(vecs[i].e_fv));
            check($sformatf("vec%0d sync_err", i), int'(sync_err), int'(vecs[i].e_err));
            if (vecs[i].e_fv) begin
                chk_frame($sformatf("vec%0d", i), int'(vecs[i].fid));
            end
            $display("vec %0d: v=%0d re=%0d im=%0d last=%0d fr=%0d -> rdy=%0d fv=%0d err=%0d in0=%0d",
                     i, vecs[i].v, vecs[i].re, vecs[i].im, vecs[i].last, vecs[i].fr,
                     s_ready, frame_valid, sync_err, in0_real);
        end

        // Continuous beats; handoff lands on the 4th beat of frames 2 and 3.
        nf = 0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            s_valid     = (k < 12);
            s_real      = 8'(20 + k);
            s_imag      = 8'(-(20 + k));
            s_last      = ((k % 4) == 3);
            frame_ready = (k == 7) || (k == 11) || (k == 12);
            if (frame_valid && frame_ready) begin
                chk_frame($sformatf("stream frame%0d", nf), 4 + nf);
                nf++;
            end
            @(posedge clk);
            #1;
            check($sformatf("stream k%0d s_ready", k), int'(s_ready), 1);
            $display("stream %0d: re=%0d fr=%0d -> rdy=%0d fv=%0d delivered=%0d",
                     k, s_real, frame_ready, s_ready, frame_valid, nf);
        end
        check("stream frames delivered", nf, 3);
        apply(0, 0, 0, 0, 0);
        check("stream drained frame_valid", int'(frame_valid), 0);

        // Mid-frame reset discards the partial frame.
        apply(1, 40, -40, 0, 0);
        apply(1, 41, -41, 0, 0);
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midreset s_ready", int'(s_ready), 0);
        check("midreset frame_valid", int'(frame_valid), 0);
        check("midreset sync_err", int'(sync_err), 0);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("midreset in%0d_real", s), get_re(s), 0);
            check($sformatf("midreset in%0d_imag", s), get_im(s), 0);
        end
        $display("reset: rdy=%0d fv=%0d in0=%0d", s_ready, frame_valid, in0_real);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after midreset s_ready", int'(s_ready), 1);
        for (int k = 0; k < 4; k++) begin
            apply(1, 9 + k, -(9 + k), k == 3, 0);
            check($sformatf("postreset k%0d frame_valid", k), int'(frame_valid), int'(k == 3));
            $display("postreset %0d: re=%0d -> fv=%0d", k, 9 + k, frame_valid);
        end
        chk_frame("postreset", 7);
        apply(0, 0, 0, 0, 1);
        check("postreset handoff frame_valid", int'(frame_valid), 0);

`ifdef IFFT4_LOADER_BITREV_EN
        // Bit-reversed placement: beats 1,2,3,4 appear as 1,3,2,4.
        for (int k = 0; k < 4; k++) begin
            apply(1, 1 + k, 0, k == 3, 0);
        end
        check("bitrev frame_valid", int'(frame_valid), 1);
        check("bitrev in0_real", int'(in0_real), 1);
        check("bitrev in1_real", int'(in1_real), 3);
        check("bitrev in2_real", int'(in2_real), 2);
        check("bitrev in3_real", int'(in3_real), 4);
        $display("bitrev: in=%0d %0d %0d %0d", in0_real, in1_real, in2_real, in3_real);
        apply(0, 0, 0, 0, 1);
        check("bitrev handoff frame_valid", int'(frame_valid), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
